axi_stream_dma_wr: RTL and testbench
====================================

# axi_stream_dma_wr

AXI-Stream to AXI4 write master that moves a commanded number of stream beats into AXI memory as INCR bursts. It sits directly upstream of the team's AXI4 RAM slave and drives its AW/W/B channels. Each command is split into legal bursts: at most MAX_BURST_LEN beats, never crossing a 4 KB boundary. One burst is outstanding at a time, and a status word is returned per command.

## Interface
- DATA_WIDTH, 32, AXI and stream data width in bits
- ADDR_WIDTH, 13, AXI address width
- STRB_WIDTH, DATA_WIDTH/8, wstrb/tkeep width; must be a power of two
- ID_WIDTH, 8, AXI ID width
- AXI_ID, 0, constant value driven on m_axi_awid
- MAX_BURST_LEN, 16, maximum beats per burst; range 1..256
- LEN_WIDTH, 16, width of the command length field

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- s_cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (treated as 0)
- s_cmd_len  in  LEN_WIDTH  total beats minus 1
- s_cmd_valid / s_cmd_ready  in/out  1  command handshake
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tkeep  in  STRB_WIDTH  byte enables, passed to wstrb
- s_axis_tvalid / s_axis_tready  in/out  1  stream handshake; tlast is not used
- m_axi_awid  out  ID_WIDTH  = AXI_ID
- m_axi_awaddr  out  ADDR_WIDTH  burst start address
- m_axi_awlen  out  8  burst beats minus 1
- m_axi_awsize  out  3  constant log2(STRB_WIDTH)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awlock / awcache / awprot  out  1/4/3  constant 0 / 4'b0011 / 0
- m_axi_awvalid / m_axi_awready  out/in  1  address handshake
- m_axi_wdata / m_axi_wstrb  out  DATA_WIDTH/STRB_WIDTH  = tdata / tkeep
- m_axi_wlast  out  1  last beat of the current burst
- m_axi_wvalid / m_axi_wready  out/in  1  write data handshake
- m_axi_bid / m_axi_bresp  in  ID_WIDTH/2  write response; bid is ignored
- m_axi_bvalid / m_axi_bready  in/out  1  response handshake
- m_status_error  out  1  1 if any burst of the command returned bresp != 2'b00
- m_status_valid / m_status_ready  out/in  1  status handshake

## Operation
- States: IDLE, ADDR, DATA, RESP, STATUS.
- IDLE: s_cmd_ready=1. On accept, latch the aligned address and remaining = len+1. Clear the error flag. Go to ADDR.
- ADDR: compute burst_beats = min(remaining, MAX_BURST_LEN, beats_to_boundary).
  - beats_to_boundary = (B - (addr mod B)) / STRB_WIDTH, where B = min(4096, 2^ADDR_WIDTH).
  - Drive awvalid=1 with awaddr=addr and awlen=burst_beats-1. Hold all AW fields stable until awready.
  - On the AW handshake: addr += burst_beats*STRB_WIDTH (modulo 2^ADDR_WIDTH); remaining -= burst_beats; load the beat counter. Go to DATA.
- DATA: wvalid = s_axis_tvalid and s_axis_tready = m_axi_wready (combinational pass-through, gated by state). wlast = 1 when the beat counter = 1. The counter decrements on each W handshake. On the wlast handshake, go to RESP.
- RESP: bready=1. On the B handshake, OR (bresp != 0) into the error flag. If remaining > 0, go to ADDR; else go to STATUS.
- STATUS: m_status_valid=1 with m_status_error. On m_status_ready, go to IDLE.
- Outside DATA: s_axis_tready=0 and wvalid=0. Stream data is never dropped or duplicated.
- Widths:
  - remaining is LEN_WIDTH+1 bits.
  - Burst arithmetic is at least 13 bits wide so that beats_to_boundary never truncates.
  - s_cmd_len = 2^LEN_WIDTH-1 is legal.

## Timing
- Reset (rst=0, asynchronous) forces IDLE and clears counters and the error flag. Outputs under reset: s_cmd_ready=0, awvalid=0, wvalid=0, s_axis_tready=0, bready=0, m_status_valid=0, m_status_error=0. s_cmd_ready rises on the first clock edge after rst returns to 1.
- Command accepted at edge N: awvalid=1 in cycle N+1.
- AW handshake at edge M: wvalid/tready may be high from cycle M+1.
- Final W handshake at edge K: bready=1 in cycle K+1.
- B handshake at edge L: awvalid=1 in L+1 (more bursts) or m_status_valid=1 in L+1.
- Zero-wait throughput: one W beat per cycle within a burst. Inter-burst overhead is at least 2 cycles plus slave B latency.
- Simultaneous s_cmd_valid while busy: ignored (s_cmd_ready=0) until the block returns to IDLE.
- Reset mid-burst: the transaction is abandoned immediately. The downstream slave must be reset together with this block.

## Test plan
- Single beat: addr 0x0100, len 0, tdata 0xA5A5A5A5 → awaddr 0x0100, awlen 0, one beat with wlast=1, then status_valid with error=0; RAM word 0x0100 = 0xA5A5A5A5.
- Splitting: addr 0x0000, len 39 (40 beats), MAX_BURST_LEN 16 → three AW handshakes: (0x0000, awlen 15), (0x0040, 15), (0x0080, 7). Exactly 40 W beats, with wlast on beats 16, 32, 40.
- 4 KB crossing: addr 0x0FF0, len 7 → (0x0FF0, awlen 3) then (0x1000, awlen 3); RAM contents match the stream order.
- Backpressure: random tvalid gaps and random wready deassertion, 20 beats → data order preserved, no extra beats, AW/W fields stable while valid and not ready.
- Error: the slave model returns SLVERR on burst 2 of 3 → all 3 bursts still complete, and status error=1. The next command (all OKAY) → error=0.
- Reset mid-DATA: assert rst=0 after 5 of 16 beats → all valids 0 and s_cmd_ready=0 immediately. After release, s_cmd_ready=1 next edge, and a fresh len 3 command completes normally.

Source files
------------

// File: rtl/axi_stream_dma_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write master and a RAM slave.
// master: drives AW/W and bready; slave: drives awready, wready and the B channel.
interface axi_stream_dma_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen,
    output m_axi_awsize, m_axi_awburst, m_axi_awlock,
    output m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen,
    input  m_axi_awsize, m_axi_awburst, m_axi_awlock,
    input  m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axi_stream_dma_wr.sv
// AXI-Stream to AXI4 write master: splits each command into INCR bursts
// (<= MAX_BURST_LEN beats, no 4 KB crossing), one burst in flight, one status per command.
// Ports: clk, rst (async active-low), s_cmd_*, s_axis_*, m_axi (AW/W/B bundle), m_status_*.
module axi_stream_dma_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH = 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  s_cmd_len,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  axi_stream_dma_wr_if.master   m_axi,
  output logic                  m_status_error,
  output logic                  m_status_valid,
  input  logic                  m_status_ready
);
  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam int RW = LEN_WIDTH + 1;
  localparam int CW = (RW > 13) ? RW : 13;
  localparam int BOUND = (ADDR_WIDTH >= 12) ? 4096 : (1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, RESP, STATUS
  } state_t;

  state_t state, state_nx;

  logic                  run;
  logic [ADDR_WIDTH-1:0] addr;
  logic [RW-1:0]         remaining;
  logic [8:0]            cnt;
  logic                  err;
  logic [CW-1:0]         off;
  logic [CW-1:0]         to_bnd;
  logic [CW-1:0]         burst;
  logic                  cmd_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  unused_bid;

  assign unused_bid = ^m_axi.m_axi_bid;

  assign m_axi.m_axi_awid    = AXI_ID;
  assign m_axi.m_axi_awaddr  = addr;
  assign m_axi.m_axi_awlen   = 8'(burst - CW'(1));
  assign m_axi.m_axi_awsize  = 3'(SIZE);
  assign m_axi.m_axi_awburst = 2'b01;
  assign m_axi.m_axi_awlock  = 1'b0;
  assign m_axi.m_axi_awcache = 4'b0011;
  assign m_axi.m_axi_awprot  = 3'b000;
  assign m_axi.m_axi_wdata   = s_axis_tdata;
  assign m_axi.m_axi_wstrb   = s_axis_tkeep;
  assign m_status_error      = err;

  // Burst size: smallest of beats left, burst cap and beats to the boundary.
  always_comb begin
    off    = CW'(addr) & CW'(BOUND - 1);
    to_bnd = (CW'(BOUND) - off) >> SIZE;
    burst  = CW'(remaining);
    if (burst > CW'(MAX_BURST_LEN)) burst = CW'(MAX_BURST_LEN);
    if (burst > to_bnd) burst = to_bnd;
  end

  assign cmd_hs = s_cmd_valid & s_cmd_ready;
  assign aw_hs  = m_axi.m_axi_awvalid & m_axi.m_axi_awready;
  assign w_hs   = m_axi.m_axi_wvalid & m_axi.m_axi_wready;
  assign b_hs   = m_axi.m_axi_bvalid & m_axi.m_axi_bready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx             = state;
    s_cmd_ready          = 1'b0;
    s_axis_tready        = 1'b0;
    m_axi.m_axi_awvalid  = 1'b0;
    m_axi.m_axi_wvalid   = 1'b0;
    m_axi.m_axi_wlast    = 1'b0;
    m_axi.m_axi_bready   = 1'b0;
    m_status_valid       = 1'b0;
    unique case (state)
      IDLE: begin
        // run keeps ready low until the first edge after reset release
        s_cmd_ready = run;
        if (s_cmd_valid && run) state_nx = ADDR;
      end
      ADDR: begin
        m_axi.m_axi_awvalid = 1'b1;
        if (m_axi.m_axi_awready) state_nx = DATA;
      end
      DATA: begin
        m_axi.m_axi_wvalid = s_axis_tvalid;
        s_axis_tready      = m_axi.m_axi_wready;
        m_axi.m_axi_wlast  = (cnt == 9'd1);
        if (w_hs && cnt == 9'd1) state_nx = RESP;
      end
      RESP: begin
        m_axi.m_axi_bready = 1'b1;
        if (m_axi.m_axi_bvalid)
          state_nx = (remaining != '0) ? ADDR : STATUS;
      end
      STATUS: begin
        m_status_valid = 1'b1;
        if (m_status_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (cmd_hs) begin
        addr      <= s_cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
        remaining <= RW'(s_cmd_len) + RW'(1);
        err       <= 1'b0;
      end
      if (aw_hs) begin
        addr      <= addr + ADDR_WIDTH'(burst << SIZE);
        remaining <= remaining - RW'(burst);
        cnt       <= 9'(burst);
      end
      if (w_hs) cnt <= cnt - 9'd1;
      if (b_hs) err <= err | (m_axi.m_axi_bresp != 2'b00);
    end
  end
endmodule

// File: tb/tb_axi_stream_dma_wr.sv
// Scoreboard bench for axi_stream_dma_wr: random stream/slave timing,
// reference burst split model, RAM slave model and status checks.
module tb_axi_stream_dma_wr;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam int MBL = 16;
  localparam int LW = 16;
  localparam int WORDS = 2048;

  typedef struct {
    int addr;
    int len;
  } aw_t;

  typedef struct {
    int         addr;
    int         len;
    logic [1:0] resp;
  } sl_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  logic clk;
  logic rst;
  logic [AW-1:0] s_cmd_addr;
  logic [LW-1:0] s_cmd_len;
  logic s_cmd_valid;
  logic s_cmd_ready;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tkeep;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic m_status_error;
  logic m_status_valid;
  logic m_status_ready;

  axi_stream_dma_wr_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW), .ID_WIDTH(IW)
  ) bus ();

  axi_stream_dma_wr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
    .ID_WIDTH(IW), .AXI_ID(8'h00),
    .MAX_BURST_LEN(MBL), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_cmd_addr(s_cmd_addr),
    .s_cmd_len(s_cmd_len),
    .s_cmd_valid(s_cmd_valid),
    .s_cmd_ready(s_cmd_ready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axi(bus),
    .m_status_error(m_status_error),
    .m_status_valid(m_status_valid),
    .m_status_ready(m_status_ready)
  );

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic       exp_st[$];
  w_t         src_q[$];
  sl_t        sl_aw[$];
  logic [1:0] pend_b[$];

  logic [31:0] ram[WORDS];
  logic [31:0] exp_mem[WORDS];

  int checks = 0;
  int failures = 0;
  bit bp = 0;
  int err_idx = -1;
  int model_aw_cnt = 0;
  int sl_aw_cnt = 0;
  int sl_beat = 0;
  int w_seen = 0;
  int wi;
  bit drop_t = 0;
  bit drop_b = 0;
  bit aw_pend = 0;
  logic [AW-1:0] pa;
  logic [7:0] pl;
  sl_t sl_new;
  aw_t ea;
  w_t ew;
  logic es;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Stream source and AXI RAM slave: inputs change at negedge,
  // handshakes are judged once they settle.
  initial begin
    forever begin
      @(negedge clk);
      if (drop_t) begin
        s_axis_tvalid = 1'b0;
        drop_t = 0;
      end
      if (drop_b) begin
        bus.m_axi_bvalid = 1'b0;
        drop_b = 0;
      end
      if (!s_axis_tvalid && src_q.size() > 0 &&
          (!bp || $urandom_range(0, 3) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata = src_q[0].data;
        s_axis_tkeep = src_q[0].strb;
      end
      if (!bus.m_axi_bvalid && pend_b.size() > 0 &&
          (!bp || $urandom_range(0, 2) == 0)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp = pend_b.pop_front();
      end
      bus.m_axi_awready = !bp || ($urandom_range(0, 2) != 0);
      bus.m_axi_wready = !bp || ($urandom_range(0, 3) != 0);
      m_status_ready = !bp || ($urandom_range(0, 1) != 0);
      #1;
      if (s_axis_tvalid && s_axis_tready) begin
        src_q.delete(0);
        drop_t = 1;
      end
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        sl_new.addr = int'(bus.m_axi_awaddr);
        sl_new.len = int'(bus.m_axi_awlen);
        sl_new.resp = (sl_aw_cnt == err_idx) ? 2'b10 : 2'b00;
        sl_aw.push_back(sl_new);
        sl_aw_cnt++;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready && sl_aw.size() > 0) begin
        wi = ((sl_aw[0].addr + sl_beat * 4) % 8192) / 4;
        for (int b = 0; b < 4; b++)
          if (bus.m_axi_wstrb[b]) ram[wi][b*8 +: 8] = bus.m_axi_wdata[b*8 +: 8];
        sl_beat++;
        if (bus.m_axi_wlast) begin
          pend_b.push_back(sl_aw[0].resp);
          sl_aw.delete(0);
          sl_beat = 0;
        end
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) drop_b = 1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        aw_pend = 0;
      end else begin
        if (aw_pend)
          chk("aw_stable",
              64'({bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen}),
              64'({1'b1, pa, pl}));
        aw_pend = bus.m_axi_awvalid && !bus.m_axi_awready;
        pa = bus.m_axi_awaddr;
        pl = bus.m_axi_awlen;
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          if (exp_aw.size() == 0) begin
            chk("aw_extra", 64'(bus.m_axi_awaddr), 64'hFFFF_FFFF);
          end else begin
            ea = exp_aw.pop_front();
            chk("aw_addr_len",
                64'({bus.m_axi_awaddr, bus.m_axi_awlen}),
                64'({13'(ea.addr), 8'(ea.len)}));
            chk("aw_const",
                64'({bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst,
                     bus.m_axi_awlock, bus.m_axi_awcache, bus.m_axi_awprot}),
                64'({8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
          end
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          w_seen++;
          if (exp_w.size() == 0) begin
            chk("w_extra", 64'(bus.m_axi_wdata), 64'h1_0000_0000);
          end else begin
            ew = exp_w.pop_front();
            chk("w_beat",
                64'({bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast}),
                64'({ew.data, ew.strb, ew.last}));
          end
        end
        if (m_status_valid && m_status_ready) begin
          if (exp_st.size() == 0) begin
            chk("status_extra", 64'(m_status_error), 64'h2);
          end else begin
            es = exp_st.pop_front();
            chk("status_error", 64'(m_status_error), 64'(es));
          end
        end
      end
    end
  end

  // Reference model: split by the burst rules, predict beats, memory, status.
  task automatic issue_cmd(input int addr, input int len, input bit rkeep,
                           input bit use_d0, input logic [31:0] d0);
    int a;
    int rem;
    int beats;
    int bnd;
    int bursts;
    int idx;
    bit got;
    aw_t na;
    w_t nw;
    a = (addr & ~3) % 8192;
    rem = len + 1;
    bursts = 0;
    while (rem > 0) begin
      bnd = (4096 - (a % 4096)) / 4;
      beats = rem;
      if (beats > MBL) beats = MBL;
      if (beats > bnd) beats = bnd;
      na.addr = a;
      na.len = beats - 1;
      exp_aw.push_back(na);
      for (int i = 0; i < beats; i++) begin
        nw.data = (use_d0 && bursts == 0 && i == 0) ? d0 : $urandom;
        nw.strb = rkeep ? 4'($urandom_range(0, 15)) : 4'hF;
        nw.last = (i == beats - 1);
        src_q.push_back(nw);
        exp_w.push_back(nw);
        idx = a / 4 + i;
        for (int b = 0; b < 4; b++)
          if (nw.strb[b]) exp_mem[idx][b*8 +: 8] = nw.data[b*8 +: 8];
      end
      a = (a + beats * 4) % 8192;
      rem -= beats;
      bursts++;
    end
    exp_st.push_back(err_idx >= model_aw_cnt && err_idx < model_aw_cnt + bursts);
    model_aw_cnt += bursts;
    @(negedge clk);
    s_cmd_addr = AW'(addr);
    s_cmd_len = LW'(len);
    s_cmd_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 5000 && !got; c++) begin
      #1;
      if (s_cmd_ready) got = 1;
      else @(negedge clk);
    end
    chk("cmd_accept", 64'(got), 64'h1);
    @(negedge clk);
    s_cmd_valid = 1'b0;
    #1;
    if (got) chk("aw_after_cmd", 64'(bus.m_axi_awvalid), 64'h1);
  endtask

  task automatic wait_done(input string name);
    int c;
    int n;
    c = 0;
    while ((exp_st.size() + exp_w.size() + exp_aw.size()) > 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done"}, 64'(exp_st.size() + exp_w.size() + exp_aw.size()), 64'h0);
    @(negedge clk);
    #3;
    n = 0;
    for (int i = 0; i < WORDS; i++)
      if (ram[i] !== exp_mem[i]) n++;
    chk({name, "_mem"}, 64'(n), 64'h0);
  endtask

  task automatic flush();
    exp_aw.delete();
    exp_w.delete();
    exp_st.delete();
    src_q.delete();
    sl_aw.delete();
    pend_b.delete();
    s_axis_tvalid = 1'b0;
    bus.m_axi_bvalid = 1'b0;
    drop_t = 0;
    drop_b = 0;
    sl_beat = 0;
    model_aw_cnt = 0;
    sl_aw_cnt = 0;
    err_idx = -1;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = ram[i];
  endtask

  initial begin
    int base;
    int c;
    rst = 1'b0;
    s_cmd_addr = '0;
    s_cmd_len = '0;
    s_cmd_valid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    m_status_ready = 1'b0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready = 1'b0;
    bus.m_axi_bid = '0;
    bus.m_axi_bresp = 2'b00;
    bus.m_axi_bvalid = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    #2;
    chk("reset_outputs",
        64'({s_cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, s_axis_tready,
             bus.m_axi_bready, m_status_valid, m_status_error}), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cmd_ready_pre_edge", 64'(s_cmd_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("cmd_ready_post_edge", 64'(s_cmd_ready), 64'h1);

    issue_cmd(32'h0100, 0, 0, 1, 32'hA5A5A5A5);
    wait_done("single");
    chk("single_word", 64'(ram[32'h0100 / 4]), 64'hA5A5A5A5);

    issue_cmd(32'h0000, 39, 0, 0, 0);
    wait_done("split");

    issue_cmd(32'h0FF0, 7, 0, 0, 0);
    wait_done("cross4k");

    issue_cmd(32'h1FF8, 5, 0, 0, 0);
    wait_done("wrap");

    bp = 1;
    issue_cmd(32'h0400, 19, 0, 0, 0);
    wait_done("backpressure");

    err_idx = model_aw_cnt + 1;
    issue_cmd(32'h0000, 39, 0, 0, 0);
    wait_done("slverr");
    err_idx = -1;
    issue_cmd(32'h0800, 9, 0, 0, 0);
    wait_done("after_err");

    for (int k = 0; k < 6; k++) begin
      issue_cmd(int'($urandom_range(0, 8191)), int'($urandom_range(0, 70)), 1, 0, 0);
      wait_done("random");
    end

    bp = 0;
    base = w_seen;
    issue_cmd(32'h0200, 15, 0, 0, 0);
    c = 0;
    while (w_seen < base + 5 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("mid_data_reached", 64'(w_seen >= base + 5), 64'h1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs",
        64'({s_cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, s_axis_tready,
             bus.m_axi_bready, m_status_valid, m_status_error}), 64'h0);
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rerun_ready_pre_edge", 64'(s_cmd_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("rerun_ready_post_edge", 64'(s_cmd_ready), 64'h1);
    issue_cmd(32'h0300, 3, 0, 0, 0);
    wait_done("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
